// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the dense-layer blocks.
//   DATA_W_DEF / FRAC_BITS_DEF : default word format (Q16.16)
//   ONE                        : fixed-point 1.0 in the default format
//   bp_state_e                 : backprop FSM states
//   sat_to_data()              : clip a wide signed value to a data_w-bit signed range
package nn_fixed_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned FRAC_BITS_DEF = 16;
    localparam logic signed [DATA_W_DEF-1:0] ONE = 32'sh0001_0000;

    // Width of the saturation helper's operand; callers sign-extend into it.
    localparam int unsigned SAT_MAX_W = 128;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } bp_state_e;

    function automatic logic signed [SAT_MAX_W-1:0] sat_to_data(
        input  logic signed [SAT_MAX_W-1:0] v,
        input  int unsigned                 data_w,
        output logic                        clipped
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        clipped = 1'b0;
        if (v > hi) begin
            clipped = 1'b1;
            return hi;
        end
        if (v < lo) begin
            clipped = 1'b1;
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/backprop_mac_lane.sv
// One column lane of the backprop accumulator.
//   en       : add (grad_out * weight) >>> FRAC_BITS to the accumulator
//   clr      : zero the accumulator (never asserted together with en)
//   grad_out : signed gradient of the current output neuron
//   weight   : signed W[r][c] for this lane
//   acc      : running signed sum, ACC_W bits wide so it cannot wrap
module backprop_mac_lane #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned ACC_W     = 51
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] grad_out,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    inc;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    always_comb begin
        prod = grad_out * weight;
        // Arithmetic shift floors toward -inf; the shifted value always fits ACC_W.
        inc  = ACC_W'(prod >>> FRAC_BITS);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dense_layer_backprop.sv
// Backward pass of a dense layer: grad_in = W^T * grad_out.
//   in_valid/in_ready  : one beat per output neuron (grad_out + weight row)
//   weight_row         : W[r][c] at [c*DATA_W +: DATA_W]
//   out_valid/out_ready: streams saturated grad_in[0..COLUMNS-1]
//   out_idx/out_last   : element index, high-on-final-element flag
//   out_sat            : current element was clipped
//   busy               : a vector is partially accumulated or draining
module dense_layer_backprop
    import nn_fixed_pkg::*;
#(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLUMNS   = 8,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            grad_out,
    input  logic [COLUMNS*DATA_W-1:0]    weight_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            grad_in,
    output logic [$clog2(COLUMNS)-1:0]   out_idx,
    output logic                         out_last,
    output logic                         out_sat,
    output logic                         busy
);

    localparam int unsigned ACC_W = 2*DATA_W - FRAC_BITS + $clog2(ROWS);
    localparam int unsigned RC_W  = $clog2(ROWS);
    localparam int unsigned CI_W  = $clog2(COLUMNS);
    localparam logic [RC_W-1:0] ROW_LAST = RC_W'(ROWS - 1);
    localparam logic [CI_W-1:0] COL_LAST = CI_W'(COLUMNS - 1);

    bp_state_e             state_q, state_d;
    logic [RC_W-1:0]       row_cnt_q, row_cnt_d;
    logic [CI_W-1:0]       col_idx_q, col_idx_d;
    logic                  accept;
    logic                  clr;
    logic signed [ACC_W-1:0] acc [COLUMNS];
    logic signed [SAT_MAX_W-1:0] sat_in;
    logic                  sat_clip;

    for (genvar c = 0; c < COLUMNS; c++) begin : g_lane
        backprop_mac_lane #(
            .DATA_W   (DATA_W),
            .FRAC_BITS(FRAC_BITS),
            .ACC_W    (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (accept),
            .clr     (clr),
            .grad_out(grad_out),
            .weight  (weight_row[c*DATA_W +: DATA_W]),
            .acc     (acc[c])
        );
    end

    // Handshake flags depend only on state, so no in_valid/out_ready feedthrough.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_idx_d = col_idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        clr       = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = DRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (col_idx_q == COL_LAST) begin
                        col_idx_d = '0;
                        clr       = 1'b1;
                        state_d   = ACCUM;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            row_cnt_q <= '0;
            col_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_idx_q <= col_idx_d;
        end
    end

    // Accumulators are frozen during DRAIN, so the muxed output is stable under stall.
    always_comb begin
        sat_in  = {{(SAT_MAX_W-ACC_W){acc[col_idx_q][ACC_W-1]}}, acc[col_idx_q]};
        grad_in = DATA_W'(sat_to_data(sat_in, DATA_W, sat_clip));
        out_sat = sat_clip & out_valid;
        if (!out_valid) begin
            grad_in = '0;
        end
    end

    assign out_idx  = col_idx_q;
    assign out_last = out_valid && (col_idx_q == COL_LAST);
    assign busy     = (state_q != ACCUM) || (row_cnt_q != '0);

endmodule

// File: tb/tb_dense_layer_backprop.sv
// Directed self-checking bench for dense_layer_backprop (ROWS=8, COLUMNS=8, Q16.16).
module tb_dense_layer_backprop;
    import nn_fixed_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  grad_out;
    logic [255:0] weight_row;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  grad_in;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         out_sat;
    logic         busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0]  e_v [8];
    logic [255:0] w1, w2, w3, wt;

    always #5 clk = ~clk;

    dense_layer_backprop #(
        .ROWS     (8),
        .COLUMNS  (8),
        .DATA_W   (32),
        .FRAC_BITS(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .grad_out  (grad_out),
        .weight_row(weight_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_in   (grad_in),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive n beats of a constant (grad, weight row) from a negedge; optionally keep in_valid high.
    task automatic send_vec(input logic [31:0] g, input logic [255:0] w, input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b1;
            grad_out   = g;
            weight_row = w;
            chk("beat_in_ready", in_ready, 1);
            chk("beat_out_valid", out_valid, 0);
            @(negedge clk);
        end
        if (!hold) in_valid = 1'b0;
        if (n == 8) begin
            chk("latency_out_valid", out_valid, 1);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_busy", busy, 1);
        end else begin
            chk("partial_busy", busy, 1);
        end
    endtask

    // Collect the 8 outputs; while stalled the same expectations are rechecked each cycle.
    task automatic drain(input logic [31:0] e [8], input logic es, input bit rnd);
        for (int i = 0; i < 8; i++) begin
            int  waited = 0;
            bit  done   = 0;
            while (!done) begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (waited > 40) out_ready = 1'b1;
                chk("out_valid", out_valid, 1);
                chk("out_idx", out_idx, 64'(i));
                chk("grad_in", grad_in, e[i]);
                chk("out_sat", out_sat, es);
                chk("out_last", out_last, (i == 7) ? 1 : 0);
                chk("drain_in_ready", in_ready, 0);
                done = out_ready;
                @(negedge clk);
                waited++;
            end
        end
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        grad_out   = '0;
        weight_row = '0;
        w1 = {8{ONE}};
        w3 = {8{32'h7FFF_FFFF}};
        wt = {8{32'h0000_8000}};
        for (int c = 0; c < 8; c++) w2[c*32 +: 32] = 32'(c) << 16;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grad_in", grad_in, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sat", out_sat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: all ones -> 8.0
        for (int c = 0; c < 8; c++) e_v[c] = 32'h0008_0000;
        send_vec(ONE, w1, 8, 0);
        drain(e_v, 1'b0, 0);

        // Test 2: W[c]=c, grad=-0.5 -> -4c
        for (int c = 0; c < 8; c++) e_v[c] = 32'(-(c * 262144));
        send_vec(32'hFFFF_8000, w2, 8, 0);
        drain(e_v, 1'b0, 0);

        // Truncation: tiny positive floors to 0, tiny negative floors to -1 per beat
        for (int c = 0; c < 8; c++) e_v[c] = 32'h0;
        send_vec(32'h0000_0001, wt, 8, 0);
        drain(e_v, 1'b0, 0);
        for (int c = 0; c < 8; c++) e_v[c] = 32'hFFFF_FFF8;
        send_vec(32'hFFFF_FFFF, wt, 8, 0);
        drain(e_v, 1'b0, 0);

        // Test 3: saturation both directions
        for (int c = 0; c < 8; c++) e_v[c] = 32'h7FFF_FFFF;
        send_vec(32'h7FFF_FFFF, w3, 8, 0);
        drain(e_v, 1'b1, 0);
        for (int c = 0; c < 8; c++) e_v[c] = 32'h8000_0000;
        send_vec(32'h8000_0000, w3, 8, 0);
        drain(e_v, 1'b1, 0);

        // Test 4: random backpressure with in_valid held high during drain
        for (int c = 0; c < 8; c++) e_v[c] = 32'(-(c * 262144));
        send_vec(32'hFFFF_8000, w2, 8, 1);
        drain(e_v, 1'b0, 1);
        in_valid = 1'b0;

        // Test 5: reset after 3 beats discards the partial sum
        send_vec(ONE, w1, 3, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 8; c++) e_v[c] = 32'h0008_0000;
        send_vec(ONE, w1, 8, 0);
        drain(e_v, 1'b0, 0);

        // Test 6: back-to-back vectors, in_valid continuous
        send_vec(ONE, w1, 8, 1);
        drain(e_v, 1'b0, 0);
        for (int c = 0; c < 8; c++) e_v[c] = 32'(-(c * 262144));
        send_vec(32'hFFFF_8000, w2, 8, 0);
        drain(e_v, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
